// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, control-bit layout used by
// decode/execute/memory stages, and the memory-stage FSM state type.
package pipeline_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Control-bit positions in the packed per-instruction control word.
  localparam int unsigned CtrlRegWrite = 0;
  localparam int unsigned CtrlMemRead  = 1;
  localparam int unsigned CtrlMemWrite = 2;
  localparam int unsigned CtrlW        = 3;

  typedef logic [CtrlW-1:0] ctrl_t;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } mem_state_e;

  // A memory op is illegal when it is both load and store, or not word aligned.
  function automatic logic mem_op_illegal(input ctrl_t ctrl, input logic [1:0] addr_lo);
    return (ctrl[CtrlMemRead] && ctrl[CtrlMemWrite]) || (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the memory stage's upstream, data-memory and write-back signals.
// The master side is the stage itself; the slave side is its environment.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);

  // Upstream (execute stage)
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_store_data;
  logic [REG_W-1:0]  in_dest;
  logic              in_reg_write;
  logic              in_mem_read;
  logic              in_mem_write;

  // Data-memory port
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Write-back bus
  logic              wb_valid;
  logic              wb_en;
  logic [REG_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  modport master (
    input  in_valid, in_alu, in_store_data, in_dest, in_reg_write, in_mem_read, in_mem_write,
    input  mem_ready, mem_rdata,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_en, wb_dest, wb_data, err
  );

  modport slave (
    output in_valid, in_alu, in_store_data, in_dest, in_reg_write, in_mem_read, in_mem_write,
    output mem_ready, mem_rdata,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_en, wb_dest, wb_data, err
  );

endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: passes non-memory results straight to write-back,
// runs loads/stores over a ready/valid memory port with arbitrary wait
// states, and flags illegal memory ops. All outputs except in_ready are
// registered; mem_ready/mem_rdata only reach flops.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = pipeline_pkg::DATA_W,
  parameter int unsigned REG_W  = pipeline_pkg::REG_W
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.master bus
);

  mem_state_e       state_q;
  logic [REG_W-1:0] dest_q;
  logic             reg_write_q;
  logic             is_load_q;

  ctrl_t in_ctrl;
  logic  in_is_mem;

  // Pack the incoming control bits into the shared control-word layout.
  always_comb begin
    in_ctrl               = '0;
    in_ctrl[CtrlRegWrite] = bus.in_reg_write;
    in_ctrl[CtrlMemRead]  = bus.in_mem_read;
    in_ctrl[CtrlMemWrite] = bus.in_mem_write;
    in_is_mem             = in_ctrl[CtrlMemRead] | in_ctrl[CtrlMemWrite];
  end

  assign bus.in_ready = (state_q == StIdle);

  // FSM with registered memory-port and write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      dest_q        <= '0;
      reg_write_q   <= 1'b0;
      is_load_q     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_en     <= 1'b0;
      bus.wb_dest   <= '0;
      bus.wb_data   <= '0;
      bus.err       <= 1'b0;
    end else begin
      // Pulses default low; wb_en/wb_dest/wb_data hold between pulses.
      bus.wb_valid <= 1'b0;
      bus.err      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (!in_is_mem) begin
              bus.wb_valid <= 1'b1;
              bus.wb_en    <= bus.in_reg_write;
              bus.wb_dest  <= bus.in_dest;
              bus.wb_data  <= bus.in_alu;
            end else if (mem_op_illegal(in_ctrl, bus.in_alu[1:0])) begin
              bus.wb_valid <= 1'b1;
              bus.wb_en    <= 1'b0;
              bus.wb_dest  <= bus.in_dest;
              bus.err      <= 1'b1;
            end else begin
              dest_q        <= bus.in_dest;
              reg_write_q   <= bus.in_reg_write;
              is_load_q     <= bus.in_mem_read;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.in_mem_write;
              bus.mem_addr  <= bus.in_alu;
              bus.mem_wdata <= bus.in_store_data;
              state_q       <= StAccess;
            end
          end
        end
        StAccess: begin
          // Request and its address/data stay put until the memory answers.
          if (bus.mem_ready) begin
            bus.mem_req  <= 1'b0;
            bus.wb_valid <= 1'b1;
            bus.wb_dest  <= dest_q;
            if (is_load_q) begin
              bus.wb_en   <= reg_write_q;
              bus.wb_data <= bus.mem_rdata;
            end else begin
              bus.wb_en   <= 1'b0;
              bus.wb_data <= '0;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_alu        = '0;
    bus.in_store_data = '0;
    bus.in_dest       = '0;
    bus.in_reg_write  = 1'b0;
    bus.in_mem_read   = 1'b0;
    bus.in_mem_write  = 1'b0;
  endtask

  task automatic present(input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] dest,
                         input logic rw, input logic rd, input logic wr);
    bus.in_valid      = 1'b1;
    bus.in_alu        = alu;
    bus.in_store_data = sdata;
    bus.in_dest       = dest;
    bus.in_reg_write  = rw;
    bus.in_mem_read   = rd;
    bus.in_mem_write  = wr;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"},   64'(bus.mem_req),   64'h0);
    chk({tag, ".mem_we"},    64'(bus.mem_we),    64'h0);
    chk({tag, ".mem_addr"},  64'(bus.mem_addr),  64'h0);
    chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'h0);
    chk({tag, ".wb_valid"},  64'(bus.wb_valid),  64'h0);
    chk({tag, ".wb_en"},     64'(bus.wb_en),     64'h0);
    chk({tag, ".wb_dest"},   64'(bus.wb_dest),   64'h0);
    chk({tag, ".wb_data"},   64'(bus.wb_data),   64'h0);
    chk({tag, ".err"},       64'(bus.err),       64'h0);
  endtask

  initial begin
    idle_inputs();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // Reset
    @(negedge clk);
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("reset.in_ready", 64'(bus.in_ready), 64'h1);
    chk("reset.wb_valid_idle", 64'(bus.wb_valid), 64'h0);

    // ALU passthrough
    present(32'h0000_00AA, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    chk("pass.wb_valid", 64'(bus.wb_valid), 64'h1);
    chk("pass.wb_en", 64'(bus.wb_en), 64'h1);
    chk("pass.wb_dest", 64'(bus.wb_dest), 64'd3);
    chk("pass.wb_data", 64'(bus.wb_data), 64'hAA);
    chk("pass.mem_req", 64'(bus.mem_req), 64'h0);
    chk("pass.in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    chk("pass.wb_valid_pulse", 64'(bus.wb_valid), 64'h0);
    chk("pass.wb_data_hold", 64'(bus.wb_data), 64'hAA);
    chk("pass.mem_req_after", 64'(bus.mem_req), 64'h0);

    // Load with 3 wait states; ready on the 4th mem_req cycle
    present(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
      chk($sformatf("load.mem_req.c%0d", i), 64'(bus.mem_req), 64'h1);
      chk($sformatf("load.mem_we.c%0d", i), 64'(bus.mem_we), 64'h0);
      chk($sformatf("load.mem_addr.c%0d", i), 64'(bus.mem_addr), 64'h100);
      chk($sformatf("load.in_ready.c%0d", i), 64'(bus.in_ready), 64'h0);
      chk($sformatf("load.wb_valid.c%0d", i), 64'(bus.wb_valid), 64'h0);
      tick();
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    chk("load.wb_valid", 64'(bus.wb_valid), 64'h1);
    chk("load.wb_en", 64'(bus.wb_en), 64'h1);
    chk("load.wb_dest", 64'(bus.wb_dest), 64'd7);
    chk("load.wb_data", 64'(bus.wb_data), 64'hDEAD_BEEF);
    chk("load.mem_req_done", 64'(bus.mem_req), 64'h0);
    chk("load.in_ready_done", 64'(bus.in_ready), 64'h1);
    // Stray mem_ready with no request must be ignored
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("stray.wb_valid", 64'(bus.wb_valid), 64'h0);
    chk("stray.wb_data_hold", 64'(bus.wb_data), 64'hDEAD_BEEF);

    // Store with 0 wait states (reg_write set to prove it is ignored)
    present(32'h0000_0040, 32'h0000_1234, 5'd2, 1'b1, 1'b0, 1'b1);
    tick();
    idle_inputs();
    bus.mem_ready = 1'b1;
    chk("store.mem_req", 64'(bus.mem_req), 64'h1);
    chk("store.mem_we", 64'(bus.mem_we), 64'h1);
    chk("store.mem_addr", 64'(bus.mem_addr), 64'h40);
    chk("store.mem_wdata", 64'(bus.mem_wdata), 64'h1234);
    chk("store.wb_valid_early", 64'(bus.wb_valid), 64'h0);
    tick();
    bus.mem_ready = 1'b0;
    chk("store.mem_req_drop", 64'(bus.mem_req), 64'h0);
    chk("store.wb_valid", 64'(bus.wb_valid), 64'h1);
    chk("store.wb_en", 64'(bus.wb_en), 64'h0);
    chk("store.wb_data", 64'(bus.wb_data), 64'h0);
    chk("store.wb_dest", 64'(bus.wb_dest), 64'd2);

    // Misaligned load
    present(32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    chk("misal.mem_req", 64'(bus.mem_req), 64'h0);
    chk("misal.err", 64'(bus.err), 64'h1);
    chk("misal.wb_valid", 64'(bus.wb_valid), 64'h1);
    chk("misal.wb_en", 64'(bus.wb_en), 64'h0);
    chk("misal.in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    chk("misal.err_pulse", 64'(bus.err), 64'h0);
    chk("misal.wb_valid_pulse", 64'(bus.wb_valid), 64'h0);
    chk("misal.mem_req_after", 64'(bus.mem_req), 64'h0);

    // Aligned but both load and store
    present(32'h0000_0080, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("both.mem_req", 64'(bus.mem_req), 64'h0);
    chk("both.err", 64'(bus.err), 64'h1);
    chk("both.wb_en", 64'(bus.wb_en), 64'h0);
    tick();

    // Reset during cycle 2 of a long load
    present(32'h0000_0200, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    chk("rstmid.mem_req_c1", 64'(bus.mem_req), 64'h1);
    tick();
    chk("rstmid.mem_req_c2", 64'(bus.mem_req), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rstmid");
    chk("rstmid.in_ready", 64'(bus.in_ready), 64'h1);
    present(32'h0000_0055, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    idle_inputs();
    chk("rstmid.pass_valid", 64'(bus.wb_valid), 64'h1);
    chk("rstmid.pass_dest", 64'(bus.wb_dest), 64'd4);
    chk("rstmid.pass_data", 64'(bus.wb_data), 64'h55);
    chk("rstmid.mem_req_after", 64'(bus.mem_req), 64'h0);
    tick();

    // Back-to-back: load (0 wait), passthrough, store (1 wait); cycle 0 = load presented
    present(32'h0000_0080, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("b2b.c0.in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    // cycle 1: load outstanding, passthrough waits upstream
    present(32'h0000_0077, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    chk("b2b.c1.mem_req", 64'(bus.mem_req), 64'h1);
    chk("b2b.c1.in_ready", 64'(bus.in_ready), 64'h0);
    chk("b2b.c1.wb_valid", 64'(bus.wb_valid), 64'h0);
    tick();
    // cycle 2: load retires, passthrough accepted at the next edge
    bus.mem_ready = 1'b0;
    chk("b2b.c2.wb_valid", 64'(bus.wb_valid), 64'h1);
    chk("b2b.c2.wb_dest", 64'(bus.wb_dest), 64'd5);
    chk("b2b.c2.wb_data", 64'(bus.wb_data), 64'hCAFE_0001);
    chk("b2b.c2.in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    // cycle 3: passthrough retires, store presented
    present(32'h0000_00C0, 32'h0000_0099, 5'd8, 1'b0, 1'b0, 1'b1);
    chk("b2b.c3.wb_valid", 64'(bus.wb_valid), 64'h1);
    chk("b2b.c3.wb_dest", 64'(bus.wb_dest), 64'd6);
    chk("b2b.c3.wb_data", 64'(bus.wb_data), 64'h77);
    chk("b2b.c3.in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    // cycle 4: store wait state
    idle_inputs();
    chk("b2b.c4.mem_req", 64'(bus.mem_req), 64'h1);
    chk("b2b.c4.mem_we", 64'(bus.mem_we), 64'h1);
    chk("b2b.c4.wb_valid", 64'(bus.wb_valid), 64'h0);
    tick();
    // cycle 5: memory answers
    bus.mem_ready = 1'b1;
    chk("b2b.c5.mem_req", 64'(bus.mem_req), 64'h1);
    chk("b2b.c5.mem_wdata", 64'(bus.mem_wdata), 64'h99);
    chk("b2b.c5.wb_valid", 64'(bus.wb_valid), 64'h0);
    tick();
    // cycle 6: store retires
    bus.mem_ready = 1'b0;
    chk("b2b.c6.wb_valid", 64'(bus.wb_valid), 64'h1);
    chk("b2b.c6.wb_en", 64'(bus.wb_en), 64'h0);
    chk("b2b.c6.wb_dest", 64'(bus.wb_dest), 64'd8);
    chk("b2b.c6.mem_req", 64'(bus.mem_req), 64'h0);
    tick();
    chk("b2b.c7.wb_valid", 64'(bus.wb_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the execute stage and register write-back. It consumes the execute-stage result: ALU output, store data, destination register and control bits. Loads and stores go through a ready/valid data-memory port with arbitrary wait states; all other instructions pass straight through. It drives the write-back bus and applies back-pressure upstream while a memory access is outstanding.

## Interface
Parameters:
- DATA_W, 32, datapath and memory word width
- REG_W, 5, destination register index width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute-stage result present
- in_ready  out  1  stage can accept; upstream holds all in_* while in_valid && !in_ready
- in_alu  in  DATA_W  ALU result (address for load/store, data otherwise)
- in_store_data  in  DATA_W  store operand
- in_dest  in  REG_W  destination register
- in_reg_write  in  1  instruction writes a register
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  word address, byte-addressed, bits [1:0] = 0
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_rdata  in  DATA_W  load data, valid when mem_ready
- wb_valid  out  1  one-cycle write-back pulse per retired instruction
- wb_en  out  1  register-file write enable (meaningful only with wb_valid)
- wb_dest  out  REG_W  write-back register
- wb_data  out  DATA_W  write-back data
- err  out  1  one-cycle pulse: illegal memory op retired

## Operation
- FSM states: IDLE, ACCESS. in_ready = (state == IDLE).
- IDLE, accept (in_valid):
  - Non-memory op: next edge wb_valid=1, wb_en=in_reg_write, wb_dest=in_dest, wb_data=in_alu. Stay in IDLE.
  - Load xor store, in_alu[1:0]==0: latch the op. Next edge mem_req=1, mem_we=in_mem_write, mem_addr=in_alu, mem_wdata=in_store_data, wb_valid=0. Go to ACCESS.
  - Illegal op (misaligned address, or mem_read && mem_write): no memory request. Next edge wb_valid=1, wb_en=0, err=1. Stay in IDLE.
- ACCESS:
  - mem_req and mem_addr/mem_we/mem_wdata hold stable until mem_ready is sampled high.
  - On the edge where mem_ready=1: mem_req=0, state goes to IDLE, wb_valid=1, wb_dest=latched dest.
  - Load: wb_en=latched reg_write, wb_data=mem_rdata.
  - Store: wb_en=0, wb_data=0.
- wb_valid and err are single-cycle pulses; wb_dest, wb_data and wb_en hold their values between pulses.
- mem_ready while mem_req=0 is ignored.

## Timing
- Reset (rst=1 at an edge): state IDLE. mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_dest, wb_data and err all 0. in_ready=1 from the cycle after reset.
- Reset mid-ACCESS abandons the request; mem_req is 0 after the reset edge. The memory must tolerate a withdrawn request.
- Non-memory latency: accepted at edge N, write-back visible after edge N+1. Throughput 1 per cycle.
- Memory latency: accepted at edge N, mem_req high after N. With mem_ready high in cycle k after N, write-back appears after edge N+k+1. Minimum 2 cycles, 0 wait states.
- in_ready returns to 1 in the cycle after completion, so back-to-back loads with zero wait states retire every 2 cycles.
- No combinational path from mem_ready or mem_rdata to any output; all outputs are registered except in_ready.

## Structure
- Shared package pipeline_pkg holds:
  - the FSM state enum (IDLE, ACCESS)
  - constants DATA_W=32 and REG_W=5
  - the pipeline control bit positions shared with the decode and execute stages
- Single module. No sub-module; the FSM and hold registers are small enough to stay inline.

## Test plan
- ALU passthrough: in_alu=0x0000_00AA, dest=3, reg_write=1, no memory bits -> next cycle wb_valid=1, wb_en=1, wb_dest=3, wb_data=0xAA. mem_req never rises.
- Load, 3 wait states: addr 0x100, dest=7, mem_ready high on the 4th cycle of mem_req with rdata=0xDEAD_BEEF -> mem_addr=0x100 stable throughout, in_ready=0 throughout, one wb_valid with wb_data=0xDEADBEEF, wb_dest=7.
- Store, 0 wait states: addr 0x40, store_data=0x1234 -> mem_req and mem_we high exactly 1 cycle with wdata=0x1234, then wb_valid=1, wb_en=0.
- Misaligned load: addr 0x102 -> no mem_req. One-cycle err and wb_valid with wb_en=0.
- Reset mid-access: rst asserted during cycle 2 of a 5-wait-state load -> mem_req=0 and all outputs 0 after that edge. A following passthrough op is accepted normally.
- Back-to-back: load (0 wait), passthrough, store (1 wait) presented continuously -> three wb_valid pulses in order at cycles 2, 3 and 6 after the first accept.
